// File: rtl/nav_bit_sync.sv
// ---------------------------------------------------------------------------
// nav_bit_sync
//
// Purpose:
//   Navigation bit synchroniser placed after the Costas carrier loop. It takes
//   one +/-1 symbol per code period, locates the data-bit boundary with a
//   transition histogram, integrates SYMS_PER_BIT symbols into a data bit and
//   hunts for the TLM preamble in either polarity. The polarity that matched
//   resolves the Costas 180 degree ambiguity, and rechecking the preamble one
//   subframe later establishes frame lock.
//
// Ports:
//   CLK            in   system clock
//   RST            in   synchronous active-high reset
//   sym_valid      in   one-cycle strobe qualifying sym_in
//   sym_in[1:0]    in   01 = +1, 11 = -1, 00/10 = erasure (0)
//   bit_valid      out  one-cycle pulse qualifying bit_out
//   bit_out        out  decided data bit, polarity corrected
//   bit_lock       out  bit boundary found (held until reset)
//   frame_lock     out  preamble confirmed at subframe spacing
//   polarity       out  1 = data inverted (matched ~PREAMBLE)
//   subframe_start out  pulse with bit_valid of the last preamble bit
//   bit_count[8:0] out  index of the current bit_out within the subframe
// ---------------------------------------------------------------------------
module nav_bit_sync #(
  parameter int         SYMS_PER_BIT  = 20,
  parameter int         LOCK_THRESH   = 16,
  parameter logic [7:0] PREAMBLE      = 8'h8B,
  parameter int         SUBFRAME_BITS = 300,
  parameter int         MAX_MISSES    = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       sym_valid,
  input  logic [1:0] sym_in,
  output logic       bit_valid,
  output logic       bit_out,
  output logic       bit_lock,
  output logic       frame_lock,
  output logic       polarity,
  output logic       subframe_start,
  output logic [8:0] bit_count
);

  localparam int             PH_W     = $clog2(SYMS_PER_BIT);
  localparam int             MISS_W   = $clog2(MAX_MISSES + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SYMS_PER_BIT - 1);
  // Index of the last preamble bit inside a subframe.
  localparam logic [8:0]     PRE_LAST = 9'd7;
  localparam logic [8:0]     CNT_LAST = 9'(SUBFRAME_BITS - 1);

  typedef enum logic [1:0] {HUNT, SEARCH, CONFIRM, FRAME_LOCK} state_t;

  state_t                  state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [PH_W-1:0]         boundary_q, boundary_d;
  logic                    have_sign_q, have_sign_d;
  logic                    last_neg_q, last_neg_d;
  logic                    started_q, started_d;
  logic signed [5:0]       acc_q, acc_d;
  logic [7:0]              sr_q, sr_d;
  logic                    pol_q, pol_d;
  logic                    fl_q, fl_d;
  logic [MISS_W-1:0]       miss_q, miss_d;
  logic [8:0]              cnt_q, cnt_d;
  logic                    bit_valid_q, bit_valid_d;
  logic                    bit_out_q, bit_out_d;
  logic                    sfs_q, sfs_d;
  logic                    bit_lock_q, bit_lock_d;
  logic [7:0]              bin_q [SYMS_PER_BIT];

  // Symbol decode: bit 0 marks a nonzero symbol, bit 1 its sign.
  logic                    sym_nz, sym_neg;
  logic signed [5:0]       sym_val;
  logic                    transition;
  logic                    lock_hit;
  logic [PH_W-1:0]         last_phase;
  logic                    accumulate, fire;
  logic signed [5:0]       bit_sum;
  logic                    raw_bit;
  logic [7:0]              sr_shift;
  logic [7:0]              exp_pat;
  logic [8:0]              cnt_inc;
  logic [SYMS_PER_BIT-1:0] bin_inc;

  assign sym_nz  = sym_in[0];
  assign sym_neg = sym_in[1];
  assign sym_val = sym_nz ? (sym_neg ? -6'sd1 : 6'sd1) : 6'sd0;

  // Erasures are invisible to the sign tracker; the very first nonzero
  // symbol only seeds it.
  assign transition = sym_valid && sym_nz && have_sign_q && (sym_neg != last_neg_q);
  assign lock_hit   = (state_q == HUNT) && transition &&
                      (bin_q[phase_q] == 8'(LOCK_THRESH - 1));

  for (genvar gi = 0; gi < SYMS_PER_BIT; gi++) begin : g_bin_inc
    assign bin_inc[gi] = (state_q == HUNT) && transition &&
                         (phase_q == PH_W'(gi)) &&
                         (bin_q[gi] != 8'(LOCK_THRESH));
  end

  // A bit spans boundary .. boundary-1 (mod SYMS_PER_BIT). Symbols seen after
  // lock but before the first boundary symbol are ignored.
  assign last_phase = (boundary_q == '0) ? PH_LAST : boundary_q - 1'b1;
  assign accumulate = sym_valid && (state_q != HUNT) &&
                      (started_q || (phase_q == boundary_q));
  assign fire       = accumulate && (phase_q == last_phase);
  assign bit_sum    = acc_q + sym_val;
  assign raw_bit    = (bit_sum > 6'sd0);
  assign sr_shift   = {sr_q[6:0], raw_bit};
  assign exp_pat    = pol_q ? ~PREAMBLE : PREAMBLE;
  assign cnt_inc    = (cnt_q == CNT_LAST) ? 9'd0 : cnt_q + 9'd1;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    boundary_d  = boundary_q;
    have_sign_d = have_sign_q;
    last_neg_d  = last_neg_q;
    started_d   = started_q;
    acc_d       = acc_q;
    sr_d        = sr_q;
    pol_d       = pol_q;
    fl_d        = fl_q;
    miss_d      = miss_q;
    cnt_d       = cnt_q;
    bit_valid_d = 1'b0;
    bit_out_d   = bit_out_q;
    sfs_d       = 1'b0;
    bit_lock_d  = bit_lock_q;

    if (sym_valid) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      if (sym_nz) begin
        have_sign_d = 1'b1;
        last_neg_d  = sym_neg;
      end
    end

    if (state_q == HUNT) begin
      if (lock_hit) begin
        state_d    = SEARCH;
        boundary_d = phase_q;
        bit_lock_d = 1'b1;
        acc_d      = '0;
        started_d  = 1'b0;
      end
    end else begin
      if (sym_valid && (phase_q == boundary_q)) begin
        started_d = 1'b1;
      end
      if (fire) begin
        acc_d       = '0;
        bit_valid_d = 1'b1;
        sr_d        = sr_shift;
        unique case (state_q)
          SEARCH: begin
            if (sr_shift == PREAMBLE) begin
              pol_d   = 1'b0;
              state_d = CONFIRM;
              cnt_d   = PRE_LAST;
            end else if (sr_shift == ~PREAMBLE) begin
              pol_d   = 1'b1;
              state_d = CONFIRM;
              cnt_d   = PRE_LAST;
            end else begin
              cnt_d   = 9'd0;
            end
          end
          CONFIRM: begin
            cnt_d = cnt_inc;
            if (cnt_inc == PRE_LAST) begin
              if (sr_shift == exp_pat) begin
                state_d = FRAME_LOCK;
                fl_d    = 1'b1;
                sfs_d   = 1'b1;
                miss_d  = '0;
              end else begin
                // Polarity is kept; the next SEARCH match re-decides it.
                state_d = SEARCH;
              end
            end
          end
          FRAME_LOCK: begin
            cnt_d = cnt_inc;
            if (cnt_inc == PRE_LAST) begin
              if (sr_shift == exp_pat) begin
                miss_d = '0;
                sfs_d  = 1'b1;
              end else if ((int'(miss_q) + 1) >= MAX_MISSES) begin
                state_d = SEARCH;
                fl_d    = 1'b0;
                miss_d  = '0;
              end else begin
                miss_d = miss_q + 1'b1;
              end
            end
          end
          default: ;
        endcase
        // Uses the polarity just decided so a matching bit is reported
        // already corrected.
        bit_out_d = raw_bit ^ pol_d;
      end else if (accumulate) begin
        acc_d = bit_sum;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= HUNT;
      phase_q     <= '0;
      boundary_q  <= '0;
      have_sign_q <= 1'b0;
      last_neg_q  <= 1'b0;
      started_q   <= 1'b0;
      acc_q       <= '0;
      sr_q        <= '0;
      pol_q       <= 1'b0;
      fl_q        <= 1'b0;
      miss_q      <= '0;
      cnt_q       <= '0;
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      sfs_q       <= 1'b0;
      bit_lock_q  <= 1'b0;
      for (int i = 0; i < SYMS_PER_BIT; i++) begin
        bin_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      boundary_q  <= boundary_d;
      have_sign_q <= have_sign_d;
      last_neg_q  <= last_neg_d;
      started_q   <= started_d;
      acc_q       <= acc_d;
      sr_q        <= sr_d;
      pol_q       <= pol_d;
      fl_q        <= fl_d;
      miss_q      <= miss_d;
      cnt_q       <= cnt_d;
      bit_valid_q <= bit_valid_d;
      bit_out_q   <= bit_out_d;
      sfs_q       <= sfs_d;
      bit_lock_q  <= bit_lock_d;
      for (int i = 0; i < SYMS_PER_BIT; i++) begin
        if (bin_inc[i]) begin
          bin_q[i] <= bin_q[i] + 8'd1;
        end
      end
    end
  end

  assign bit_valid      = bit_valid_q;
  assign bit_out        = bit_out_q;
  assign bit_lock       = bit_lock_q;
  assign frame_lock     = fl_q;
  assign polarity       = pol_q;
  assign subframe_start = sfs_q;
  // Outside CONFIRM/FRAME_LOCK the counter is held at 0 on every bit.
  assign bit_count      = cnt_q;

endmodule

// File: tb/tb_nav_bit_sync.sv
// ---------------------------------------------------------------------------
// tb_nav_bit_sync
//
// Purpose:
//   Randomised bench for nav_bit_sync. Builds bit streams (boundary at stream
//   phase 5, preambles every 300 bits), turns them into symbol streams
//   (optionally negated, with erasures and flipped symbols), and compares the
//   DUT against a behavioural model that keeps the histogram as an int array,
//   the current bit as a queue of symbols and the decided bits as a queue.
// ---------------------------------------------------------------------------
module tb_nav_bit_sync;

  localparam int         SPB  = 20;
  localparam int         TH   = 16;
  localparam logic [7:0] PRE  = 8'h8B;
  localparam logic [7:0] NPRE = ~PRE;
  localparam int         SFB  = 300;
  localparam int         MAXM = 2;
  localparam int         MAXB = 1700;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       sym_valid = 1'b0;
  logic [1:0] sym_in = 2'b00;
  logic       bit_valid, bit_out, bit_lock, frame_lock, polarity, subframe_start;
  logic [8:0] bit_count;

  always #5 CLK = ~CLK;

  nav_bit_sync #(
    .SYMS_PER_BIT (SPB),
    .LOCK_THRESH  (TH),
    .PREAMBLE     (PRE),
    .SUBFRAME_BITS(SFB),
    .MAX_MISSES   (MAXM)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .sym_valid     (sym_valid),
    .sym_in        (sym_in),
    .bit_valid     (bit_valid),
    .bit_out       (bit_out),
    .bit_lock      (bit_lock),
    .frame_lock    (frame_lock),
    .polarity      (polarity),
    .subframe_start(subframe_start),
    .bit_count     (bit_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  int sfs_seen = 0;
  int fl_seen  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int  m_phase;
  int  m_bins [SPB];
  bit  m_have, m_last_pos, m_lock;
  int  m_bound;
  int  m_st;            // 0 hunt, 1 search, 2 confirm, 3 frame lock
  bit  m_coll;
  int  m_syms [$];
  bit  m_hist [$];
  bit  m_pol, m_fl;
  int  m_cnt, m_miss;
  bit  e_fire, e_bit, e_sfs;

  task automatic model_reset();
    m_phase = 0;
    foreach (m_bins[i]) m_bins[i] = 0;
    m_have = 0; m_last_pos = 0; m_lock = 0; m_bound = 0; m_st = 0; m_coll = 0;
    m_syms.delete(); m_hist.delete();
    m_pol = 0; m_fl = 0; m_cnt = 0; m_miss = 0;
  endtask

  task automatic frame_step(input bit raw);
    int w, expw;
    m_hist.push_back(raw);
    if (m_hist.size() > 8) void'(m_hist.pop_front());
    w = 0;
    foreach (m_hist[i]) w = (w << 1) | int'(m_hist[i]);
    expw = m_pol ? int'(NPRE) : int'(PRE);
    case (m_st)
      1: begin
        if (w == int'(PRE)) begin m_pol = 0; m_st = 2; m_cnt = 7; end
        else if (w == int'(NPRE)) begin m_pol = 1; m_st = 2; m_cnt = 7; end
        else m_cnt = 0;
      end
      2: begin
        m_cnt = (m_cnt + 1) % SFB;
        if (m_cnt == 7) begin
          if (w == expw) begin m_st = 3; m_fl = 1; e_sfs = 1; m_miss = 0; end
          else m_st = 1;
        end
      end
      default: begin
        m_cnt = (m_cnt + 1) % SFB;
        if (m_cnt == 7) begin
          if (w == expw) begin m_miss = 0; e_sfs = 1; end
          else begin
            m_miss++;
            if (m_miss >= MAXM) begin m_st = 1; m_fl = 0; m_miss = 0; end
          end
        end
      end
    endcase
    e_fire = 1;
    e_bit  = raw ^ m_pol;
  endtask

  task automatic model_step(input int v);
    int ph, sum;
    bit trans;
    ph = m_phase;
    m_phase = (m_phase + 1) % SPB;
    trans = 0;
    if (v != 0) begin
      trans = m_have && ((v > 0) != m_last_pos);
      m_have = 1;
      m_last_pos = (v > 0);
    end
    if (m_st == 0) begin
      if (trans) begin
        if (m_bins[ph] < TH) m_bins[ph]++;
        if (m_bins[ph] == TH) begin
          m_lock = 1; m_bound = ph; m_st = 1; m_coll = 0; m_syms.delete();
        end
      end
    end else begin
      if (ph == m_bound) begin m_coll = 1; m_syms.delete(); end
      if (m_coll) m_syms.push_back(v);
      if (m_syms.size() == SPB) begin
        sum = 0;
        foreach (m_syms[i]) sum += m_syms[i];
        m_syms.delete();
        frame_step(sum > 0);
      end
    end
  endtask

  // ---------------- stream construction ----------------
  bit src     [MAXB];
  int mode    [MAXB];   // 0 clean, 1 erasures+flip, 2 all erasure
  bit planted [MAXB];   // last bit of an intact preamble
  bit fixedb  [MAXB];   // may not be altered by the scrubber
  bit lead;

  task automatic flip_in_window(input int e);
    for (int j = e; j >= 0 && j > e - 8; j--) begin
      if (!fixedb[j]) begin
        src[j] = ~src[j];
        return;
      end
    end
  endtask

  task automatic build_stream(input int nbits, input int npre, input int corrupt, input bit noisy);
    logic [7:0] pv;
    int p, w8, w7;
    bit changed;
    pv = PRE;
    lead = 1'($urandom_range(0, 1));
    for (int b = 0; b < nbits; b++) begin
      src[b] = 1'($urandom_range(0, 1));
      mode[b] = (noisy && b >= 150) ? 1 : 0;
      planted[b] = 0;
      fixedb[b] = 0;
    end
    for (int k = 0; k < npre; k++) begin
      p = 100 + SFB * k;
      for (int j = 0; j < 8; j++) begin
        src[p + j] = pv[7 - j];
        fixedb[p + j] = 1;
      end
      if (corrupt[k]) src[p + 7] = ~src[p + 7];
      else planted[p + 7] = 1;
    end
    if (noisy) begin
      src[250] = 0; mode[250] = 2; fixedb[250] = 1;
      src[251] = 0; mode[251] = 2; fixedb[251] = 1;
      src[900] = 0; mode[900] = 2; fixedb[900] = 1;
    end
    // Remove accidental preambles (either polarity), and near the start also
    // 7-bit tails that would match ~PREAMBLE behind the zeroed shift register.
    for (int it = 0; it < 100; it++) begin
      changed = 0;
      for (int e = 6; e < nbits; e++) begin
        if (e >= 7) begin
          w8 = 0;
          for (int j = e - 7; j <= e; j++) w8 = (w8 << 1) | int'(src[j]);
          if ((w8 == int'(PRE) || w8 == int'(NPRE)) && !planted[e]) begin
            flip_in_window(e);
            changed = 1;
          end
        end
        if (e < 100) begin
          w7 = 0;
          for (int j = e - 6; j <= e; j++) w7 = (w7 << 1) | int'(src[j]);
          if (w7 == 7'b1110100 || w7 == 7'b0001011) begin
            flip_in_window(e);
            changed = 1;
          end
        end
      end
      if (!changed) break;
    end
  endtask

  // ---------------- drive one cycle and compare ----------------
  task automatic drive(input bit vld, input logic [1:0] code, input int v,
                       input int b, input int md, input bit neg);
    @(negedge CLK);
    sym_valid = vld;
    sym_in    = code;
    e_fire = 0;
    e_sfs  = 0;
    if (vld) model_step(v);
    @(posedge CLK);
    #1;
    check("bit_valid", int'(bit_valid), int'(e_fire));
    check("subframe_start", int'(subframe_start), int'(e_fire && e_sfs));
    check("bit_lock", int'(bit_lock), int'(m_lock));
    check("frame_lock", int'(frame_lock), int'(m_fl));
    check("polarity", int'(polarity), int'(m_pol));
    if (subframe_start) sfs_seen++;
    if (frame_lock) fl_seen = 1;
    if (e_fire) begin
      check("bit_out", int'(bit_out), int'(e_bit));
      check("bit_count", int'(bit_count), m_cnt);
      if (b >= 0 && md == 2) check("erased_bit", int'(bit_out), int'(m_pol));
      else if (b >= 0 && m_pol == neg) check("source_bit", int'(bit_out), int'(src[b]));
      $display("bit src_idx=%0d out=%0d cnt=%0d pol=%0d fl=%0d sfs=%0d",
               b, bit_out, bit_count, polarity, frame_lock, subframe_start);
    end
  endtask

  task automatic run_stream(input int nbits, input bit neg, input int stop_sym);
    int np [4];
    int b, k, md, v, base, c, r;
    bit sb, dup;
    logic [1:0] code;
    for (int s = 0; s < 5 + nbits * SPB; s++) begin
      if (s == stop_sym) return;
      if (s < 5) begin b = -1; k = 15 + s; sb = lead; md = 0; end
      else begin b = (s - 5) / SPB; k = (s - 5) % SPB; sb = src[b]; md = mode[b]; end
      if (k == 0 && md == 1) begin
        c = 0;
        while (c < 4) begin
          r = $urandom_range(0, SPB - 1);
          dup = 0;
          for (int j = 0; j < c; j++) if (np[j] == r) dup = 1;
          if (!dup) begin np[c] = r; c++; end
        end
      end
      base = (sb ? 1 : -1) * (neg ? -1 : 1);
      v = base;
      if (md == 2) v = 0;
      else if (md == 1) begin
        if (k == np[0] || k == np[1] || k == np[2]) v = 0;
        else if (k == np[3]) v = -base;
      end
      if (v == 1) code = 2'b01;
      else if (v == -1) code = 2'b11;
      else code = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
      if ($urandom_range(0, 7) == 0) drive(1'b0, 2'b01, 0, -1, 0, neg);
      drive(1'b1, code, v, b, md, neg);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bit_valid"}, int'(bit_valid), 0);
    check({tag, "_bit_out"}, int'(bit_out), 0);
    check({tag, "_bit_lock"}, int'(bit_lock), 0);
    check({tag, "_frame_lock"}, int'(frame_lock), 0);
    check({tag, "_polarity"}, int'(polarity), 0);
    check({tag, "_subframe_start"}, int'(subframe_start), 0);
    check({tag, "_bit_count"}, int'(bit_count), 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    sym_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("reset");
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();

    // A: positive stream, 6 preambles; #2, #4, #5 corrupted; noise after bit 150.
    build_stream(1620, 6, 32'b110100, 1'b1);
    do_reset();
    sfs_seen = 0; fl_seen = 0;
    run_stream(1620, 1'b0, -1);
    check("A_subframe_pulses", sfs_seen, 2);
    check("A_frame_lock_seen", fl_seen, 1);
    check("A_frame_lock_dropped", int'(frame_lock), 0);

    // B: negated stream, 3 preambles; reset mid-bit while frame locked.
    build_stream(720, 3, 0, 1'b0);
    do_reset();
    sfs_seen = 0;
    run_stream(720, 1'b1, 5 + 710 * SPB + 9);
    check("B_subframe_pulses", sfs_seen, 2);
    check("B_polarity", int'(polarity), 1);
    check("B_frame_lock", int'(frame_lock), 1);
    @(negedge CLK);
    RST = 1'b1;
    sym_valid = 1'b1;
    sym_in = 2'b01;
    @(posedge CLK);
    #1;
    check_all_zero("midrst");
    @(negedge CLK);
    RST = 1'b0;
    sym_valid = 1'b0;
    model_reset();

    // C: fresh stream relocks from a cleared histogram.
    build_stream(120, 0, 0, 1'b0);
    run_stream(120, 1'b0, -1);
    check("C_bit_lock", int'(bit_lock), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
